// File: rtl/tl_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tl_mem_responder
//  Purpose  : Multi-channel TileLink-UL memory responder. Every channel
//             accepts single-beat Get / PutFullData / PutPartialData requests
//             against one shared word store. Responses are returned in order
//             through a per-channel queue with a minimum latency and
//             back-pressure.
//  Ports    : clk, rst_n             clock, asynchronous active-low reset
//             a_*_i / a_ready_o      A channel, channel c in slice c
//             d_*_o / d_ready_i      D channel, channel c in slice c
//             err_o                  sticky protocol error per channel
//  Revision : 1.0  initial release
// ============================================================================
module tl_mem_responder #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int SRC_W     = 8,
   parameter int SIZE_W    = 4,
   parameter int OP_W      = 3,
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4,
   parameter int DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            a_valid_i,
   output logic [NUM_CH-1:0]            a_ready_o,
   input  logic [NUM_CH*OP_W-1:0]       a_opcode_i,
   input  logic [NUM_CH*SIZE_W-1:0]     a_size_i,
   input  logic [NUM_CH*SRC_W-1:0]      a_source_i,
   input  logic [NUM_CH*ADDR_W-1:0]     a_address_i,
   input  logic [NUM_CH*DATA_W/8-1:0]   a_mask_i,
   input  logic [NUM_CH*DATA_W-1:0]     a_data_i,
   input  logic [NUM_CH*3-1:0]          a_param_i,
   output logic [NUM_CH-1:0]            d_valid_o,
   input  logic [NUM_CH-1:0]            d_ready_i,
   output logic [NUM_CH*OP_W-1:0]       d_opcode_o,
   output logic [NUM_CH*SIZE_W-1:0]     d_size_o,
   output logic [NUM_CH*SRC_W-1:0]      d_source_o,
   output logic [NUM_CH*DATA_W-1:0]     d_data_o,
   output logic [NUM_CH*3-1:0]          d_param_o,
   output logic [NUM_CH-1:0]            err_o
);

   localparam int c_mask_w = DATA_W / 8;
   localparam int c_ofs    = $clog2(c_mask_w);
   localparam int c_idx_w  = $clog2(MEM_WORDS);
   localparam int c_ptr_w  = $clog2(DEPTH);
   localparam int c_cd_w   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [OP_W-1:0]    c_op_put_full = OP_W'(0);
   localparam logic [OP_W-1:0]    c_op_put_part = OP_W'(1);
   localparam logic [OP_W-1:0]    c_op_get      = OP_W'(4);
   localparam logic [OP_W-1:0]    c_op_ack      = OP_W'(0);
   localparam logic [OP_W-1:0]    c_op_ack_data = OP_W'(1);
   localparam logic [SIZE_W-1:0]  c_ofs_size    = SIZE_W'(c_ofs);
   localparam logic [c_cd_w-1:0]  c_cd_init     = c_cd_w'(LATENCY - 1);
   localparam logic [c_ptr_w:0]   c_depth       = (c_ptr_w + 1)'(DEPTH);

   // Shared backing store. Deliberately not reset: contents survive rst_n.
   logic [DATA_W-1:0]  r_mem [MEM_WORDS];

   // Gates a_ready so it stays low during reset and rises on the first edge
   // after release.
   logic               r_ready_en;

   logic [NUM_CH-1:0]  w_a_fire;
   logic [NUM_CH-1:0]  w_is_get;
   logic [NUM_CH-1:0]  w_is_put;
   logic [c_idx_w-1:0] w_idx     [NUM_CH];
   logic [DATA_W-1:0]  w_rd_data [NUM_CH];

   // Parameter field and address bits outside the word index carry no meaning.
   logic               w_unused_ok;
   assign w_unused_ok = ^{a_param_i, a_address_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
      end
   end

   // Writes from all channels in one block: later (higher) channels are
   // assigned last, so they win on overlapping bytes. Reads sample r_mem
   // combinationally at acceptance, so a same-cycle read sees pre-write data.
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int b = 0; b < c_mask_w; b++) begin
            if (w_a_fire[ch] && w_is_put[ch] && a_mask_i[ch*c_mask_w + b]) begin
               r_mem[w_idx[ch]][b*8 +: 8] <= a_data_i[ch*DATA_W + b*8 +: 8];
            end
         end
      end
   end

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         logic [OP_W-1:0]    w_op;
         logic [SIZE_W-1:0]  w_size;
         logic               w_bad;
         logic               w_head_valid;
         logic               w_d_fire;

         logic [OP_W-1:0]    r_q_op   [DEPTH];
         logic [SIZE_W-1:0]  r_q_size [DEPTH];
         logic [SRC_W-1:0]   r_q_src  [DEPTH];
         logic [DATA_W-1:0]  r_q_data [DEPTH];
         logic [c_cd_w-1:0]  r_q_cd   [DEPTH];
         logic [c_ptr_w-1:0] r_wr_ptr;
         logic [c_ptr_w-1:0] r_rd_ptr;
         logic [c_ptr_w:0]   r_count;
         logic               r_err;

         assign w_op         = a_opcode_i[c*OP_W +: OP_W];
         assign w_size       = a_size_i[c*SIZE_W +: SIZE_W];
         assign w_is_get[c]  = (w_op == c_op_get);
         assign w_is_put[c]  = (w_op == c_op_put_full) || (w_op == c_op_put_part);
         // Unknown opcodes and multi-beat sizes are still answered, but flagged.
         assign w_bad        = !(w_is_get[c] || w_is_put[c]) || (w_size > c_ofs_size);
         assign w_idx[c]     = a_address_i[c*ADDR_W + c_ofs +: c_idx_w];
         assign w_rd_data[c] = r_mem[w_idx[c]];

         // Ready depends only on occupancy, never on this cycle's pop.
         assign a_ready_o[c] = r_ready_en && (r_count < c_depth);
         assign w_a_fire[c]  = a_valid_i[c] && a_ready_o[c];

         assign w_head_valid = (r_count != '0) && (r_q_cd[r_rd_ptr] == '0);
         assign w_d_fire     = w_head_valid && d_ready_i[c];

         // Payload is forced to zero whenever nothing is presented, so reset
         // and idle both show an all-zero D bus.
         assign d_valid_o[c]                    = w_head_valid;
         assign d_opcode_o[c*OP_W +: OP_W]      = w_head_valid ? r_q_op[r_rd_ptr]   : '0;
         assign d_size_o[c*SIZE_W +: SIZE_W]    = w_head_valid ? r_q_size[r_rd_ptr] : '0;
         assign d_source_o[c*SRC_W +: SRC_W]    = w_head_valid ? r_q_src[r_rd_ptr]  : '0;
         assign d_data_o[c*DATA_W +: DATA_W]    = w_head_valid ? r_q_data[r_rd_ptr] : '0;
         assign d_param_o[c*3 +: 3]             = 3'b000;
         assign err_o[c]                        = r_err;

         // Queue storage needs no reset: occupancy is tracked by r_count and
         // every slot is fully rewritten when pushed.
         always_ff @(posedge clk) begin
            // Every countdown runs down in parallel, so entries behind the
            // head mature meanwhile and can leave back-to-back.
            for (int i = 0; i < DEPTH; i++) begin
               if (r_q_cd[i] != '0) begin
                  r_q_cd[i] <= r_q_cd[i] - c_cd_w'(1);
               end
            end
            if (w_a_fire[c]) begin
               r_q_op[r_wr_ptr]   <= w_is_get[c] ? c_op_ack_data : c_op_ack;
               r_q_size[r_wr_ptr] <= w_size;
               r_q_src[r_wr_ptr]  <= a_source_i[c*SRC_W +: SRC_W];
               r_q_data[r_wr_ptr] <= w_is_get[c] ? w_rd_data[c] : '0;
               r_q_cd[r_wr_ptr]   <= c_cd_init;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
               r_err    <= 1'b0;
            end else begin
               if (w_a_fire[c]) begin
                  r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
               end
               if (w_d_fire) begin
                  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
               end
               case ({w_a_fire[c], w_d_fire})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
               if (w_a_fire[c] && w_bad) begin
                  r_err <= 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_mem_responder
//  Purpose  : Self-checking bench for tl_mem_responder (2 channels, 128-bit
//             beats, LATENCY 4, DEPTH 4). Stimulus pushes expected responses
//             into per-channel queues; a monitor compares on each D handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tl_mem_responder;

   localparam int NUM_CH = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int SRC_W  = 8;
   localparam int SIZE_W = 4;
   localparam int OP_W   = 3;
   localparam int MASK_W = 16;

   localparam logic [2:0] c_put_full = 3'd0;
   localparam logic [2:0] c_put_part = 3'd1;
   localparam logic [2:0] c_get      = 3'd4;

   localparam logic [127:0] c_dead  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] c_merge = 128'hDEADBEEF_DEADBEEF_DEADBEEF_11112222;
   localparam logic [127:0] c_cafe  = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_CH-1:0]          a_valid_i;
   logic [NUM_CH-1:0]          a_ready_o;
   logic [NUM_CH*OP_W-1:0]     a_opcode_i;
   logic [NUM_CH*SIZE_W-1:0]   a_size_i;
   logic [NUM_CH*SRC_W-1:0]    a_source_i;
   logic [NUM_CH*ADDR_W-1:0]   a_address_i;
   logic [NUM_CH*MASK_W-1:0]   a_mask_i;
   logic [NUM_CH*DATA_W-1:0]   a_data_i;
   logic [NUM_CH*3-1:0]        a_param_i;
   logic [NUM_CH-1:0]          d_valid_o;
   logic [NUM_CH-1:0]          d_ready_i;
   logic [NUM_CH*OP_W-1:0]     d_opcode_o;
   logic [NUM_CH*SIZE_W-1:0]   d_size_o;
   logic [NUM_CH*SRC_W-1:0]    d_source_o;
   logic [NUM_CH*DATA_W-1:0]   d_data_o;
   logic [NUM_CH*3-1:0]        d_param_o;
   logic [NUM_CH-1:0]          err_o;

   tl_mem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_valid_i   (a_valid_i),
      .a_ready_o   (a_ready_o),
      .a_opcode_i  (a_opcode_i),
      .a_size_i    (a_size_i),
      .a_source_i  (a_source_i),
      .a_address_i (a_address_i),
      .a_mask_i    (a_mask_i),
      .a_data_i    (a_data_i),
      .a_param_i   (a_param_i),
      .d_valid_o   (d_valid_o),
      .d_ready_i   (d_ready_i),
      .d_opcode_o  (d_opcode_o),
      .d_size_o    (d_size_o),
      .d_source_o  (d_source_o),
      .d_data_o    (d_data_o),
      .d_param_o   (d_param_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]   op;
      logic [3:0]   size;
      logic [7:0]   src;
      logic [127:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [2:0] op, input logic [3:0] size,
                       input logic [7:0] src, input logic [127:0] data);
      exp_t e;
      e = '{op: op, size: size, src: src, data: data};
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   // ---------------- monitor: compare on every D handshake ----------------
   exp_t m_e;
   exp_t m_act;
   logic m_have;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (d_valid_o[c] && d_ready_i[c]) begin
               m_have = 1'b0;
               m_e    = '0;
               if (c == 0 && q0.size() > 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
               if (c == 1 && q1.size() > 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
               m_act = '{op:   d_opcode_o[c*OP_W +: OP_W],
                         size: d_size_o[c*SIZE_W +: SIZE_W],
                         src:  d_source_o[c*SRC_W +: SRC_W],
                         data: d_data_o[c*DATA_W +: DATA_W]};
               if (!m_have) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp ch%0d: got %h expected none", c, m_act);
               end else begin
                  chk($sformatf("resp_ch%0d_src%02h", c, m_e.src), 160'(m_act), 160'(m_e));
               end
               chk($sformatf("param_ch%0d", c), 160'(d_param_o[c*3 +: 3]), 160'(0));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_a(input int ch, input logic [2:0] op, input logic [3:0] size,
                        input logic [7:0] src, input logic [31:0] addr,
                        input logic [15:0] mask, input logic [127:0] data);
      a_valid_i[ch]                   = 1'b1;
      a_opcode_i[ch*OP_W +: OP_W]     = op;
      a_size_i[ch*SIZE_W +: SIZE_W]   = size;
      a_source_i[ch*SRC_W +: SRC_W]   = src;
      a_address_i[ch*ADDR_W +: ADDR_W] = addr;
      a_mask_i[ch*MASK_W +: MASK_W]   = mask;
      a_data_i[ch*DATA_W +: DATA_W]   = data;
   endtask

   // Presents the currently driven requests for one edge; returns which were accepted.
   task automatic go(output logic [1:0] acc);
      @(negedge clk);
      acc = a_valid_i & a_ready_o;
      @(posedge clk);
      #1;
      a_valid_i = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || d_valid_o != '0) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({"drain_", name}, 160'(q0.size() + q1.size()), 160'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [1:0] acc;
   int         k;
   int         sent;

   initial begin
      rst_n       = 1'b0;
      a_valid_i   = '0;
      a_opcode_i  = '0;
      a_size_i    = '0;
      a_source_i  = '0;
      a_address_i = '0;
      a_mask_i    = '0;
      a_data_i    = '0;
      a_param_i   = '0;
      d_ready_i   = 2'b11;

      // Reset values
      repeat (3) @(posedge clk);
      #2;
      chk("rst_a_ready", 160'(a_ready_o), 160'(0));
      chk("rst_d_valid", 160'(d_valid_o), 160'(0));
      chk("rst_err",     160'(err_o),     160'(0));
      chk("rst_d_data",  160'(d_data_o[127:0]), 160'(0));
      chk("rst_d_src",   160'(d_source_o), 160'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_a_ready", 160'(a_ready_o), 160'(2'b11));

      // PutFull + latency check
      set_a(0, c_put_full, 4'd4, 8'h12, 32'h100, 16'hFFFF, c_dead);
      go(acc);
      chk("put_acc", 160'(acc), 160'(2'b01));
      push(0, 3'd0, 4'd4, 8'h12, 128'h0);
      k = 0;
      while (k < 10) begin
         @(negedge clk);
         k++;
         if (d_valid_o[0]) break;
      end
      chk("latency", 160'(k), 160'(4));
      @(posedge clk);
      #1;

      // Get readback
      set_a(0, c_get, 4'd4, 8'h13, 32'h100, 16'h0, 128'h0);
      go(acc);
      push(0, 3'd1, 4'd4, 8'h13, c_dead);
      wait_drain("get");

      // Same-cycle partial writes, higher channel wins on overlap
      set_a(0, c_put_part, 4'd4, 8'h14, 32'h100, 16'h000F, {16{8'h11}});
      set_a(1, c_put_part, 4'd4, 8'h24, 32'h100, 16'h0003, {16{8'h22}});
      go(acc);
      chk("partial_acc", 160'(acc), 160'(2'b11));
      push(0, 3'd0, 4'd4, 8'h14, 128'h0);
      push(1, 3'd0, 4'd4, 8'h24, 128'h0);
      set_a(0, c_get, 4'd4, 8'h15, 32'h100, 16'h0, 128'h0);
      go(acc);
      push(0, 3'd1, 4'd4, 8'h15, c_merge);
      wait_drain("partial");

      // Same-cycle write and read on different channels: read sees old data
      set_a(0, c_put_full, 4'd4, 8'h20, 32'h100, 16'hFFFF, c_cafe);
      set_a(1, c_get,      4'd4, 8'h21, 32'h100, 16'h0,    128'h0);
      go(acc);
      chk("rw_acc", 160'(acc), 160'(2'b11));
      push(0, 3'd0, 4'd4, 8'h20, 128'h0);
      push(1, 3'd1, 4'd4, 8'h21, c_merge);
      set_a(1, c_get, 4'd4, 8'h22, 32'h100, 16'h0, 128'h0);
      go(acc);
      push(1, 3'd1, 4'd4, 8'h22, c_cafe);
      wait_drain("rw");

      // Back-pressure
      d_ready_i[0] = 1'b0;
      sent = 0;
      for (int cyc = 0; cyc < 12 && sent < 6; cyc++) begin
         set_a(0, c_get, 4'd4, 8'(sent), 32'h100, 16'h0, 128'h0);
         go(acc);
         if (acc[0]) begin
            push(0, 3'd1, 4'd4, 8'(sent), c_cafe);
            sent++;
         end
      end
      chk("bp_accepted", 160'(sent), 160'(4));
      chk("bp_a_ready",  160'(a_ready_o[0]), 160'(0));
      d_ready_i[0] = 1'b1;
      for (int cyc = 0; cyc < 20 && sent < 6; cyc++) begin
         set_a(0, c_get, 4'd4, 8'(sent), 32'h100, 16'h0, 128'h0);
         go(acc);
         if (acc[0]) begin
            push(0, 3'd1, 4'd4, 8'(sent), c_cafe);
            sent++;
         end
      end
      chk("bp_total", 160'(sent), 160'(6));
      wait_drain("bp");

      // Error path: bad opcode (must not write), then multi-beat Get
      set_a(1, 3'd2, 4'd4, 8'h30, 32'h100, 16'hFFFF, 128'h0);
      go(acc);
      push(1, 3'd0, 4'd4, 8'h30, 128'h0);
      chk("err_after_op", 160'(err_o), 160'(2'b10));
      set_a(1, c_get, 4'd6, 8'h31, 32'h100, 16'h0, 128'h0);
      go(acc);
      push(1, 3'd1, 4'd6, 8'h31, c_cafe);
      wait_drain("err");
      chk("err_sticky", 160'(err_o), 160'(2'b10));

      // Reset mid-operation
      d_ready_i[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_a(0, c_get, 4'd4, 8'(8'h40 + i), 32'h100, 16'h0, 128'h0);
         go(acc);
      end
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_valid", 160'(d_valid_o[0]), 160'(1));
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 160'(d_valid_o), 160'(0));
      chk("async_rst_ready", 160'(a_ready_o), 160'(0));
      chk("async_rst_err",   160'(err_o),     160'(0));
      d_ready_i = 2'b11;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel2_a_ready", 160'(a_ready_o), 160'(2'b11));
      set_a(0, c_get, 4'd4, 8'h50, 32'h100, 16'h0, 128'h0);
      go(acc);
      push(0, 3'd1, 4'd4, 8'h50, c_cafe);
      wait_drain("after_rst");
      repeat (8) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
